// File: rtl/mor1kx_ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: port A writes, port B reads with a registered output.
// Optional synchronous flush input is compiled in when MOR1KX_RAM_FIFO_FLUSH_EN is defined.
module mor1kx_ram_fifo_ctrl #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef MOR1KX_RAM_FIFO_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic [DEPTH_WIDTH:0]   level,
    output logic [DEPTH_WIDTH-1:0] ram_addr_a,
    output logic                   ram_we_a,
    output logic [DATA_WIDTH-1:0]  ram_din_a,
    output logic [DEPTH_WIDTH-1:0] ram_addr_b,
    output logic                   ram_we_b,
    output logic [DATA_WIDTH-1:0]  ram_din_b,
    input  logic [DATA_WIDTH-1:0]  ram_dout_b
);

    localparam logic [DEPTH_WIDTH:0] DEPTH_L = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] ZERO_L  = {(DEPTH_WIDTH+1){1'b0}};

    logic                   flush_s;
    logic                   push_s;
    logic                   pop_s;
    logic [DEPTH_WIDTH-1:0] wr_ptr_r;
    logic [DEPTH_WIDTH-1:0] rd_ptr_r;
    logic [DEPTH_WIDTH-1:0] wr_ptr_next_s;
    logic [DEPTH_WIDTH-1:0] rd_ptr_next_s;
    logic [DEPTH_WIDTH-1:0] rd_addr_s;
    logic [DEPTH_WIDTH:0]   level_r;
    logic [DEPTH_WIDTH:0]   level_less_pop_s;
    logic [DEPTH_WIDTH:0]   level_next_s;
    logic                   full_r;
    logic                   head_ready_r;
    logic                   head_ready_next_s;

`ifdef MOR1KX_RAM_FIFO_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Handshake qualification; flush blocks both sides for the cycle.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (flush_s) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = in_valid & ~full_r;
            pop_s  = head_ready_r & out_ready;
        end
    end

    // Next-state arithmetic for pointers, occupancy and the head-ready flag.
    always_comb begin
        wr_ptr_next_s     = wr_ptr_r + DEPTH_WIDTH'(push_s);
        rd_ptr_next_s     = rd_ptr_r + DEPTH_WIDTH'(pop_s);
        level_less_pop_s  = level_r - (DEPTH_WIDTH+1)'(pop_s);
        level_next_s      = level_less_pop_s + (DEPTH_WIDTH+1)'(push_s);
        // A same-cycle push is not yet in the RAM when port B samples, so it is excluded.
        head_ready_next_s = (level_less_pop_s != ZERO_L);
    end

    // Read-address steering: follow the post-pop head so the RAM fetches it on the retiring edge.
    always_comb begin
        rd_addr_s = {DEPTH_WIDTH{1'b0}};
        if (flush_s) begin
            rd_addr_s = {DEPTH_WIDTH{1'b0}};
        end else begin
            rd_addr_s = rd_ptr_next_s;
        end
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {DEPTH_WIDTH{1'b0}};
            rd_ptr_r     <= {DEPTH_WIDTH{1'b0}};
            level_r      <= ZERO_L;
            full_r       <= 1'b0;
            head_ready_r <= 1'b0;
        end else if (flush_s) begin
            wr_ptr_r     <= {DEPTH_WIDTH{1'b0}};
            rd_ptr_r     <= {DEPTH_WIDTH{1'b0}};
            level_r      <= ZERO_L;
            full_r       <= 1'b0;
            head_ready_r <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            level_r      <= level_next_s;
            full_r       <= (level_next_s == DEPTH_L);
            head_ready_r <= head_ready_next_s;
        end
    end

    assign in_ready   = ~full_r & ~flush_s;
    assign out_valid  = head_ready_r;
    assign out_data   = ram_dout_b;
    assign level      = level_r;
    assign ram_addr_a = wr_ptr_r;
    assign ram_we_a   = push_s;
    assign ram_din_a  = in_data;
    assign ram_addr_b = rd_addr_s;
    assign ram_we_b   = 1'b0;
    assign ram_din_b  = {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mor1kx_ram_fifo_ctrl.sv
// Bench for mor1kx_ram_fifo_ctrl: external RAM model, queue-based reference model, directed tests.
module tb_mor1kx_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_tb = 1'b0;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [4:0]  level;
    logic [3:0]  ram_addr_a;
    logic        ram_we_a;
    logic [31:0] ram_din_a;
    logic [3:0]  ram_addr_b;
    logic        ram_we_b;
    logic [31:0] ram_din_b;
    logic [31:0] ram_dout_b;

    int checks   = 0;
    int failures = 0;

    mor1kx_ram_fifo_ctrl #(.DEPTH_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MOR1KX_RAM_FIFO_FLUSH_EN
        .flush      (flush_tb),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_din_a  (ram_din_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // External dual-port RAM with registered port-B output (old data on collision).
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an entry becomes visible two cycles after its push cycle, once it is at the head.
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ent_t;
    ent_t        q[$];
    int          t = 0;
    logic [3:0]  wr_cnt = 4'd0;
    logic [3:0]  rd_cnt = 4'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        exp_in_ready, exp_valid, exp_push, exp_pop;
    logic [3:0]  exp_addr_b;
    int          sz;
    ent_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            wr_cnt     = 4'd0;
            rd_cnt     = 4'd0;
            prev_stall = 1'b0;
        end else begin
            sz           = q.size();
            exp_in_ready = (sz != 16) && !flush_tb;
            exp_valid    = (sz > 0) && (q[0].cyc <= t - 2);
            exp_push     = in_valid && exp_in_ready;
            exp_pop      = exp_valid && out_ready && !flush_tb;
            exp_addr_b   = flush_tb ? 4'd0 : rd_cnt + {3'd0, exp_pop};
            chk("in_ready", in_ready, exp_in_ready);
            chk("level", level, sz);
            chk("out_valid", out_valid, exp_valid);
            chk("ram_we_a", ram_we_a, exp_push);
            chk("ram_addr_a", ram_addr_a, wr_cnt);
            chk("ram_addr_b", ram_addr_b, exp_addr_b);
            chk("ram_we_b", ram_we_b, 1'b0);
            chk("ram_din_b", ram_din_b, 32'd0);
            if (exp_push) chk("ram_din_a", ram_din_a, in_data);
            if (exp_valid) chk("out_data", out_data, q[0].data);
            if (prev_stall && exp_valid) chk("stall_stable", out_data, prev_data);
            if (ram_we_a && (ram_addr_a == ram_addr_b))
                chk("collision_live", ((sz - (exp_pop ? 1 : 0)) >= 1), 1'b0);
            prev_stall = exp_valid && !out_ready && !flush_tb;
            prev_data  = out_data;
            if (flush_tb) begin
                q.delete();
                wr_cnt = 4'd0;
                rd_cnt = 4'd0;
            end else begin
                if (exp_pop) begin
                    void'(q.pop_front());
                    rd_cnt = rd_cnt + 4'd1;
                end
                if (exp_push) begin
                    e.data = in_data;
                    e.cyc  = t;
                    q.push_back(e);
                    wr_cnt = wr_cnt + 4'd1;
                end
            end
        end
        t++;
    end

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_tb  = 1'b0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int pushed;
    int budget;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_we_a", ram_we_a, 1'b0);
        chk("rst_addr_a", ram_addr_a, 4'd0);
        chk("rst_addr_b", ram_addr_b, 4'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single push, two-cycle latency.
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_n1_valid", out_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("single_n2_valid", out_valid, 1'b1);
        chk("single_n2_data", out_data, 32'hA5A5_0001);
        cyc();
        @(negedge clk);
        chk("single_n3_valid", out_valid, 1'b0);
        chk("single_n3_level", level, 5'd0);

        // Fill to full, then attempt a 17th push.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cyc();
        end
        in_data = 32'd16;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_level", level, 5'd16);
        chk("full_no_write", ram_we_a, 1'b0);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, i);
            cyc();
        end
        @(negedge clk);
        chk("drain_end_valid", out_valid, 1'b0);
        chk("drain_end_level", level, 5'd0);
        chk("drain_wrap_a", ram_addr_a, 4'd0);
        chk("drain_wrap_b", ram_addr_b, 4'd0);

        // Streaming with random stalls.
        do_reset();
        pushed = 0;
        budget = 0;
        while (pushed < 1000 && budget < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 32'h1000_0000 + pushed;
            if (in_valid && in_ready) pushed++;
            cyc();
            budget++;
        end
        chk("stream_pushed", pushed, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while ((out_valid || level != 5'd0) && budget < 64) begin
            cyc();
            budget++;
        end
        chk("stream_drained", (level == 5'd0) && !out_valid, 1'b1);

        // Asynchronous reset mid-stream with level 5.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h2000_0000 + i;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("pre_rst_level", level, 5'd5);
        chk("pre_rst_valid", out_valid, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 1'b0);
        chk("async_level", level, 5'd0);
        chk("async_addr_a", ram_addr_a, 4'd0);
        chk("async_addr_b", ram_addr_b, 4'd0);
        cyc();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0BAD_F00D;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_data", out_data, 32'h0BAD_F00D);
        cyc();

`ifdef MOR1KX_RAM_FIFO_FLUSH_EN
        // Flush at level 7 with push and pop both requested.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3000_0000 + i;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("pre_flush_level", level, 5'd7);
        cyc();
        flush_tb  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_0007;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_we_a", ram_we_a, 1'b0);
        chk("flush_addr_b", ram_addr_b, 4'd0);
        cyc();
        flush_tb = 1'b0;
        in_data  = 32'hC0DE_0042;
        @(negedge clk);
        chk("post_flush_level", level, 5'd0);
        chk("post_flush_valid", out_valid, 1'b0);
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("flush_push_valid", out_valid, 1'b1);
        chk("flush_push_data", out_data, 32'hC0DE_0042);
        cyc();
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mor1kx_ram_fifo_ctrl.md
# mor1kx_ram_fifo_ctrl

Single-clock FIFO controller that drives an external true dual-port RAM: port A is the write port and port B the read port. It provides a valid/ready push interface upstream and a show-ahead valid/ready pop interface downstream. Pop data is taken directly from the RAM's registered port-B output, so the controller owns pointers, occupancy and read-address steering, not data storage. It sits in front of the dual-port RAM and supplies the RAM's port addresses, write enables and write data.

## Interface
- DEPTH_WIDTH, 4: log2 of FIFO depth; the RAM must have at least 2^DEPTH_WIDTH words.
- DATA_WIDTH, 32: entry width.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an entry.
- in_data  in  DATA_WIDTH  entry to push.
- in_ready  out  1  FIFO accepts the entry this cycle.
- out_valid  out  1  head entry is presented on out_data.
- out_data  out  DATA_WIDTH  head entry; equals ram_dout_b.
- out_ready  in  1  downstream consumes the head this cycle.
- level  out  DEPTH_WIDTH+1  current occupancy.
- ram_addr_a  out  DEPTH_WIDTH  write address (wr_ptr).
- ram_we_a  out  1  write strobe.
- ram_din_a  out  DATA_WIDTH  write data (in_data).
- ram_addr_b  out  DEPTH_WIDTH  read address.
- ram_we_b  out  1  tied 0.
- ram_din_b  out  DATA_WIDTH  tied 0.
- ram_dout_b  in  DATA_WIDTH  registered RAM read data, one cycle after ram_addr_b.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (level != 2^DEPTH_WIDTH). When full, the FIFO does not accept a push in the same cycle as a pop.
- ram_we_a = push; ram_addr_a = wr_ptr; wr_ptr increments on push and wraps modulo 2^DEPTH_WIDTH.
- rd_ptr_next = rd_ptr + pop (wraps). ram_addr_b = rd_ptr_next, combinational.
  - The RAM therefore reads the new head on the same edge that the pop retires the old head.
- level_next = level + push − pop, computed in DEPTH_WIDTH+1 bits. It never under- or overflows.
- Head-ready flag:
  - head_ready_next = (level − pop) ≥ 1.
  - An entry pushed in the current cycle is excluded, because it is not yet in the RAM when port B samples.
  - out_valid = head_ready.
- Stall behaviour: while out_valid & !out_ready, ram_addr_b stays equal to rd_ptr, so the RAM re-reads the same occupied slot.
  - That slot cannot be written (wr_ptr never equals an occupied slot), so out_data stays stable.
- Address collision: ram_addr_b may equal ram_addr_a during a write only when level − pop = 0.
  - The read result for that cycle is discarded, because head_ready_next = 0.
  - No other collision is possible.
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, level = 0, out_valid = 0.
  - Resulting outputs: in_ready = 1, ram_we_a = 0, ram_addr_a = 0, ram_addr_b = 0.

## Timing
- Push-to-out_valid latency into an empty FIFO: push at cycle N → out_valid at N+2, with out_data = the pushed value.
- Throughput: one push and one pop per cycle in steady state (level between 1 and depth−1).
- Pop at cycle M with level ≥ 2: the next entry is on out_data at M+1 with out_valid still 1. There are no bubbles.
- Pop of the last entry at M: out_valid = 0 at M+1.
- Push into an empty FIFO while a previous pop is draining: same two-cycle latency as above.
- level updates on the edge following push or pop; at full, in_ready deasserts the cycle after the filling push.

## Configuration
- MOR1KX_RAM_FIFO_FLUSH_EN defined: adds input port flush (1 bit, synchronous, active-high).
  - When flush is high, the next edge sets wr_ptr = rd_ptr = 0, level = 0 and out_valid = 0.
  - flush overrides push and pop in the same cycle: in_ready = 0 and ram_we_a = 0 while flush is high, and pop is ignored.
  - ram_addr_b = 0 during the flush cycle.
- MOR1KX_RAM_FIFO_FLUSH_EN not defined: no flush port; behaviour is exactly as described above.

## Test plan
- Reset, then single push of 0xA5A5_0001 at cycle N, out_ready = 1 → out_valid = 1 at N+2 with out_data 0xA5A5_0001; out_valid = 0 at N+3; level returns to 0.
- DEPTH_WIDTH = 4, push 16 words 0..15 with out_ready = 0 → in_ready = 0 and level = 16 after the 16th push; the 17th word is not written (ram_we_a stays 0).
- From full, out_ready = 1 for 16 cycles → out_data sequence 0..15 on consecutive cycles; pointers wrap to 0; out_valid drops after word 15.
- Continuous push and pop with random out_ready stalls over 1000 words → output order and values match input; out_data stays stable through every stall; the bench flags any ram_addr_a == ram_addr_b collision on a cycle where head_ready_next = 1.
- Assert rst_n low asynchronously mid-stream with level = 5 → out_valid, level and pointers are 0 immediately, without waiting for a clock edge; the first push after release reappears at N+2.
- With MOR1KX_RAM_FIFO_FLUSH_EN, flush with level = 7 while in_valid = 1 and out_ready = 1 → nothing is written or popped; level = 0 and out_valid = 0 next cycle; a push the following cycle is output two cycles later.
